// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate instruction issue on
// read-after-write hazards and on counter saturation, with same-cycle writeback forwarding.
module reg_scoreboard #(
  parameter int unsigned NREG   = 128,
  parameter int unsigned IW     = 7,
  parameter int unsigned CW     = 2,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [IW-1:0]   iss_rd1,
  input  logic [IW-1:0]   iss_rd2,
  input  logic [IW-1:0]   iss_wr,
  input  logic            wb_valid,
  input  logic [IW-1:0]   wb_reg,
  input  logic            flush,
  output logic            stall,
  output logic            iss_fire,
  output logic [NREG-1:0] busy,
  output logic [7:0]      inflight,
  output logic            err_underflow
);

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};
  localparam logic [CW-1:0] CntOne = CW'(1);

  // Out-of-range indices alias to register 0, which is never tracked.
  function automatic logic [IW-1:0] f_norm(input logic [IW-1:0] idx);
    if (32'(idx) < NREG) return idx;
    return '0;
  endfunction

  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] w_cnt_d [NREG];
  logic [7:0]    r_inflight;
  logic [7:0]    w_inflight_d;
  logic          r_err;

  logic [IW-1:0] w_rd1, w_rd2, w_wr, w_wb;
  logic [CW-1:0] w_cnt_rd1, w_cnt_rd2, w_cnt_wr, w_cnt_wb;
  logic          w_fwd1, w_fwd2, w_haz1, w_haz2, w_sat;
  logic          w_inc, w_dec, w_under;

  assign w_rd1 = f_norm(iss_rd1);
  assign w_rd2 = f_norm(iss_rd2);
  assign w_wr  = f_norm(iss_wr);
  assign w_wb  = f_norm(wb_reg);

  assign w_cnt_rd1 = r_cnt[w_rd1];
  assign w_cnt_rd2 = r_cnt[w_rd2];
  assign w_cnt_wr  = r_cnt[w_wr];
  assign w_cnt_wb  = r_cnt[w_wb];

  // A source may proceed only if the writeback retiring this cycle is its last pending writer.
  assign w_fwd1 = FWD_EN && wb_valid && (w_wb == w_rd1) && (w_cnt_rd1 == CntOne);
  assign w_fwd2 = FWD_EN && wb_valid && (w_wb == w_rd2) && (w_cnt_rd2 == CntOne);
  assign w_haz1 = (w_rd1 != '0) && (w_cnt_rd1 != '0) && !w_fwd1;
  assign w_haz2 = (w_rd2 != '0) && (w_cnt_rd2 != '0) && !w_fwd2;
  assign w_sat  = (w_wr != '0) && (w_cnt_wr == CntMax);

  assign stall    = iss_valid && (w_haz1 || w_haz2 || w_sat);
  assign iss_fire = iss_valid && !stall;

  assign w_inc   = iss_fire && (w_wr != '0);
  assign w_dec   = wb_valid && (w_wb != '0) && (w_cnt_wb != '0);
  assign w_under = wb_valid && (w_wb != '0) && (w_cnt_wb == '0);

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (flush) begin
        w_cnt_d[i] = '0;
      end else if (w_inc && (w_wr == IW'(i)) && !(w_dec && (w_wb == IW'(i)))) begin
        w_cnt_d[i] = r_cnt[i] + CntOne;
      end else if (w_dec && (w_wb == IW'(i)) && !(w_inc && (w_wr == IW'(i)))) begin
        w_cnt_d[i] = r_cnt[i] - CntOne;
      end
    end
  end

  // Total saturates rather than wrapping when many registers are pending at once.
  always_comb begin
    w_inflight_d = r_inflight;
    if (flush) begin
      w_inflight_d = '0;
    end else if (w_inc && !w_dec) begin
      if (r_inflight != 8'hFF) w_inflight_d = r_inflight + 8'd1;
    end else if (w_dec && !w_inc) begin
      if (r_inflight != 8'h00) w_inflight_d = r_inflight - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_cnt[i] <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) r_cnt[i] <= w_cnt_d[i];
      r_inflight <= w_inflight_d;
      r_err      <= r_err | w_under;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) busy[i] = (r_cnt[i] != '0);
  end

  assign inflight      = r_inflight;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each stimulus row queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_reg_scoreboard;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iss_valid = 1'b0;
  logic [6:0]   iss_rd1 = '0, iss_rd2 = '0, iss_wr = '0, wb_reg = '0;
  logic         wb_valid = 1'b0, flush = 1'b0;
  logic         stall, iss_fire, err_underflow;
  logic [127:0] busy;
  logic [7:0]   inflight;

  reg_scoreboard #(.NREG(128), .IW(7), .CW(2), .FWD_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_rd1      (iss_rd1),
    .iss_rd2      (iss_rd2),
    .iss_wr       (iss_wr),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .stall        (stall),
    .iss_fire     (iss_fire),
    .busy         (busy),
    .inflight     (inflight),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic       fire;
    logic [7:0] inflight;
    logic       err;
    logic [6:0] bidx;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input string field, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "stall", int'(stall), int'(e.stall));
      chk(e.name, "iss_fire", int'(iss_fire), int'(e.fire));
      chk(e.name, "inflight", int'(inflight), int'(e.inflight));
      chk(e.name, "err_underflow", int'(err_underflow), int'(e.err));
      chk(e.name, $sformatf("busy[%0d]", e.bidx), int'(busy[e.bidx]), int'(e.busy));
    end
  end

  // Inputs change 1 time unit after the edge; expectations describe the cycle's negedge view.
  task automatic step(input string nm, input logic rn, input logic v,
                      input logic [6:0] r1, input logic [6:0] r2, input logic [6:0] w,
                      input logic wv, input logic [6:0] wr, input logic fl,
                      input logic es, input logic ef, input logic [7:0] einf,
                      input logic eerr, input logic [6:0] bidx, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; iss_valid = v; iss_rd1 = r1; iss_rd2 = r2; iss_wr = w;
    wb_valid = wv; wb_reg = wr; flush = fl;
    e.name = nm; e.stall = es; e.fire = ef; e.inflight = einf;
    e.err = eerr; e.bidx = bidx; e.busy = eb;
    q.push_back(e);
  endtask

  initial begin
    //    name          rn v  r1 r2 w   wv wr fl  st fi inf er bi  bb
    step("reset",       0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 5,  0);
    step("idle0",       1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 5,  0);
    // RAW on r5 with forwarding
    step("iss_wr5",     1, 1, 0, 0, 5,  0, 0, 0,  0, 1, 0, 0, 5,  0);
    step("raw5",        1, 1, 5, 0, 0,  0, 0, 0,  1, 0, 1, 0, 5,  1);
    step("fwd5",        1, 1, 5, 0, 0,  1, 5, 0,  0, 1, 1, 0, 5,  1);
    step("after_fwd5",  1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 5,  0);
    // Saturation on r9
    step("wr9_a",       1, 1, 0, 0, 9,  0, 0, 0,  0, 1, 0, 0, 9,  0);
    step("wr9_b",       1, 1, 0, 0, 9,  0, 0, 0,  0, 1, 1, 0, 9,  1);
    step("wr9_c",       1, 1, 0, 0, 9,  0, 0, 0,  0, 1, 2, 0, 9,  1);
    step("wr9_sat",     1, 1, 0, 0, 9,  0, 0, 0,  1, 0, 3, 0, 9,  1);
    step("wr9_sat_wb",  1, 1, 0, 0, 9,  1, 9, 0,  1, 0, 3, 0, 9,  1);
    step("wr9_again",   1, 1, 0, 0, 9,  0, 0, 0,  0, 1, 2, 0, 9,  1);
    step("wr9_full",    1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 3, 0, 9,  1);
    step("wb9_a",       1, 0, 0, 0, 0,  1, 9, 0,  0, 0, 3, 0, 9,  1);
    step("wb9_b",       1, 0, 0, 0, 0,  1, 9, 0,  0, 0, 2, 0, 9,  1);
    step("wb9_c",       1, 0, 0, 0, 0,  1, 9, 0,  0, 0, 1, 0, 9,  1);
    step("r9_drained",  1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 9,  0);
    // Same-cycle issue and writeback on r12
    step("wr12",        1, 1, 0, 0, 12, 0, 0, 0,  0, 1, 0, 0, 12, 0);
    step("wr12_wb12",   1, 1, 0, 0, 12, 1, 12, 0, 0, 1, 1, 0, 12, 1);
    step("r12_held",    1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 12, 1);
    step("wb12",        1, 0, 0, 0, 0,  1, 12, 0, 0, 0, 1, 0, 12, 1);
    step("r12_empty",   1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 12, 0);
    // Underflow on r20, sticky through flush
    step("wb20_under",  1, 0, 0, 0, 0,  1, 20, 0, 0, 0, 0, 0, 20, 0);
    step("err_set",     1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 20, 0);
    step("flush_err",   1, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 1, 20, 0);
    step("err_kept",    1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 20, 0);
    // Register 0 ignored, HI/LO index tracked, flush beats issue
    step("iss_r0",      1, 1, 0, 0, 0,  0, 0, 0,  0, 1, 0, 1, 0,  0);
    step("r0_uncount",  1, 1, 0, 0, 33, 0, 0, 0,  0, 1, 0, 1, 0,  0);
    step("busy33",      1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 33, 1);
    step("flush_iss3",  1, 1, 0, 0, 3,  0, 0, 1,  0, 1, 1, 1, 33, 1);
    step("flushed33",   1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 33, 0);
    step("flushed3",    1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 3,  0);
    // rd2 hazard, no forwarding with two writers pending, then async reset
    step("wr7",         1, 1, 0, 0, 7,  0, 0, 0,  0, 1, 0, 1, 7,  0);
    step("wr8_a",       1, 1, 0, 0, 8,  0, 0, 0,  0, 1, 1, 1, 7,  1);
    step("wr8_b",       1, 1, 0, 0, 8,  0, 0, 0,  0, 1, 2, 1, 8,  1);
    step("raw8_nofwd",  1, 1, 0, 8, 0,  1, 8, 0,  1, 0, 3, 1, 8,  1);
    step("wr10",        1, 1, 0, 0, 10, 0, 0, 0,  0, 1, 2, 1, 8,  1);
    step("wr11",        1, 1, 0, 0, 11, 0, 0, 0,  0, 1, 3, 1, 10, 1);
    step("inflight4",   1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 4, 1, 7,  1);
    step("async_rst",   0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 7,  0);
    step("in_rst",      0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 11, 0);
    step("rst_release", 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 8,  0);
    step("post_rst_rd", 1, 1, 7, 8, 0,  0, 0, 0,  0, 1, 0, 0, 7,  0);
    step("post_rst_id", 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 7,  0);

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, default 128, number of tracked registers (GPR 0-31 plus HI/LO/system registers, 7-bit index space).
REQ-002 Parameter IW, default 7, register index width; NREG SHALL be <= 2**IW.
REQ-003 Parameter CW, default 2, per-register pending-write counter width; max in-flight writers per register = 2**CW-1.
REQ-004 Parameter FWD_EN, default 1, 1 = same-cycle writeback bypasses the RAW stall.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 iss_valid  in  1  decoded instruction presented for issue.
REQ-008 iss_rd1  in  IW  first source register index, 0 = none.
REQ-009 iss_rd2  in  IW  second source register index, 0 = none.
REQ-010 iss_wr  in  IW  destination register index, 0 = none.
REQ-011 wb_valid  in  1  a write completes this cycle.
REQ-012 wb_reg  in  IW  register written back.
REQ-013 flush  in  1  clear all pending state (pipeline already drained/killed by caller).
REQ-014 stall  out  1  issue blocked this cycle (combinational).
REQ-015 iss_fire  out  1  iss_valid & ~stall; instruction accepted.
REQ-016 busy  out  NREG  bit i = counter[i] != 0 (registered state).
REQ-017 inflight  out  8  total pending writes across all registers.
REQ-018 err_underflow  out  1  sticky: writeback to a register with zero pending count.

Function
REQ-019 Index 0 SHALL never be busy, never stall, never be counted; writes/writebacks to 0 are ignored.
REQ-020 Indices >= NREG SHALL be treated as index 0.
REQ-021 RAW: stall SHALL assert when iss_valid and iss_rd1 or iss_rd2 has counter != 0, except (FWD_EN=1) when wb_valid & wb_reg == that index & counter == 1.
REQ-022 Saturation: stall SHALL assert when iss_valid and counter[iss_wr] == 2**CW-1, regardless of same-cycle writeback.
REQ-023 stall SHALL be 0 when iss_valid = 0; stall has no cycle latency (same-cycle decision).
REQ-024 On iss_fire with iss_wr != 0, counter[iss_wr] SHALL increment at the next edge.
REQ-025 On wb_valid with wb_reg != 0 and counter > 0, counter[wb_reg] SHALL decrement at the next edge.
REQ-026 Same register incremented and decremented in one cycle: counter unchanged.
REQ-027 wb_valid to a register with counter 0: counter stays 0, err_underflow sets at next edge and holds until reset.
REQ-028 inflight SHALL equal the sum of all counters at every cycle: +1 on counted issue, -1 on counted writeback, net 0 when both; saturates at 255 and never wraps.
REQ-029 flush SHALL zero all counters and inflight at the next edge and take priority over same-cycle issue/writeback; stall evaluated from pre-flush state that cycle; err_underflow unaffected.
REQ-030 No state changes when iss_valid & stall (rejected issue has no side effect).

Reset
REQ-031 While rst_n = 0, all counters, busy, inflight and err_underflow SHALL be 0 immediately (asynchronous); stall and iss_fire follow REQ-023 and are 0 with iss_valid = 0.
REQ-032 Reset deasserting mid-operation SHALL discard all pending writes; first edge after release behaves as an empty scoreboard.

Verification
REQ-033 Issue wr=5, next cycle issue rd1=5 with no writeback -> stall=1, busy[5]=1, inflight=1; assert wb_valid wb_reg=5 (FWD_EN=1) -> stall=0 same cycle, iss_fire=1, busy[5]=0 next cycle.
REQ-034 CW=2: three issues wr=9 then fourth issue wr=9 -> stall=1, counter 3 held; one writeback of 9 -> next issue accepted, inflight=3.
REQ-035 Same cycle iss_fire wr=12 and wb_valid wb_reg=12 with counter 1 -> counter stays 1, inflight unchanged.
REQ-036 wb_valid wb_reg=20 with counter 0 -> err_underflow=1 next cycle and stays 1 through flush; busy[20]=0.
REQ-037 Issue wr=0, rd1=0 and wr=7'd33 (HI/LO) -> no counting for 0, busy[33]=1; flush with simultaneous issue wr=3 -> all busy 0, inflight=0.
REQ-038 Pull rst_n low between clock edges with inflight=4 -> busy, inflight, err_underflow 0 before next edge.
